aes_serial_round_ctrl: RTL

//  Round sequencer for the 16-bit (2 bytes/cycle) DSbox AES-128 datapath register file.

---
 rtl/aes_ctrl_pkg.sv | 31 +++
 rtl/aes_serial_round_ctrl_cnt.sv | 53 +++++
 rtl/aes_serial_round_ctrl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/aes_ctrl_pkg.sv
// aes_ctrl_pkg: shared state encoding and sizing for the
// serial AES-128 round sequencer.
package aes_ctrl_pkg;

  localparam int AES_NR    = 10;
  localparam int AES_BEATS = 8;
  localparam int BEAT_W    = 3;
  localparam int ROUND_W   = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SR,
    ALIGN,
    PASS,
    OUT,
    DONE
  } state_t;

  typedef struct packed {
    logic busy;
    logic done;
    logic load_phase;
    logic cipher_valid;
    logic dp_en;
    logic dp_doSR;
    logic dp_doMC;
    logic rk_next;
  } ctrl_t;

endpackage

// File: rtl/aes_serial_round_ctrl_cnt.sv
// aes_round_beat_cnt: beat counter (wrap/clear) and
// saturating round counter for the AES round sequencer.
import aes_ctrl_pkg::*;

module aes_round_beat_cnt #(
  parameter int NR    = AES_NR,
  parameter int BEATS = AES_BEATS
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               beat_inc,
  input  logic               round_clr,
  input  logic               round_inc,
  output logic [BEAT_W-1:0]  beat,
  output logic [BEAT_W-1:0]  beat_nxt,
  output logic [ROUND_W-1:0] round,
  output logic               last_beat,
  output logic               last_round
);

  logic [ROUND_W-1:0] round_nxt;

  assign last_beat  = beat == BEAT_W'(BEATS - 1);
  assign last_round = round == ROUND_W'(NR);

  always_comb begin
    beat_nxt = beat;
    if (clr)
      beat_nxt = '0;
    else if (beat_inc)
      beat_nxt = last_beat ? '0 : beat + 1'b1;
  end

  always_comb begin
    round_nxt = round;
    if (round_clr)
      round_nxt = '0;
    else if (round_inc && !last_round)
      round_nxt = round + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat  <= '0;
      round <= '0;
    end else begin
      beat  <= beat_nxt;
      round <= round_nxt;
    end
  end

endmodule

// File: rtl/aes_serial_round_ctrl.sv
// aes_serial_round_ctrl: round sequencer for the 16-bit DSbox AES-128
// datapath. Define DSBOX_ALIGN_EN to add the 1-byte ALIGN shift cycle.
import aes_ctrl_pkg::*;

module aes_serial_round_ctrl #(
  parameter int NR    = AES_NR,
  parameter int BEATS = AES_BEATS
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               load_phase,
  output logic               cipher_valid,
  output logic               dp_en,
  output logic               dp_doSR,
  output logic               dp_doMC,
  output logic [ROUND_W-1:0] round,
  output logic [BEAT_W-1:0]  beat,
  output logic               rk_next
);

  state_t state;
  state_t state_n;

  logic              beat_inc;
  logic              round_inc;
  logic              round_clr;
  logic              clr;
  logic              last_beat;
  logic              last_round;
  logic [BEAT_W-1:0] beat_nxt;

  ctrl_t ctrl_n;
  ctrl_t ctrl_q;

  aes_round_beat_cnt #(
    .NR    (NR),
    .BEATS (BEATS)
  ) u_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .beat_inc   (beat_inc),
    .round_clr  (round_clr),
    .round_inc  (round_inc),
    .beat       (beat),
    .beat_nxt   (beat_nxt),
    .round      (round),
    .last_beat  (last_beat),
    .last_round (last_round)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n   = state;
    beat_inc  = 1'b0;
    round_inc = 1'b0;
    unique case (state)
      IDLE: begin
        if (start)
          state_n = LOAD;
      end
      LOAD, PASS: begin
        beat_inc = 1'b1;
        if (last_beat) begin
          round_inc = 1'b1;
          state_n   = SR;
        end
      end
`ifdef DSBOX_ALIGN_EN
      SR: state_n = ALIGN;
      ALIGN: state_n = last_round ? OUT : PASS;
`else
      SR: state_n = last_round ? OUT : PASS;
`endif
      OUT: begin
        beat_inc = 1'b1;
        if (last_beat)
          state_n = DONE;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign clr       = state_n != state;
  assign round_clr = (state_n == IDLE) || (state_n == LOAD);

  // Outputs are decoded from next state/beat so they leave a flop.
  always_comb begin
    ctrl_n              = '0;
    ctrl_n.busy         = (state_n == LOAD) || (state_n == SR) ||
                          (state_n == ALIGN) || (state_n == PASS) ||
                          (state_n == OUT);
    ctrl_n.done         = state_n == DONE;
    ctrl_n.load_phase   = state_n == LOAD;
    ctrl_n.cipher_valid = state_n == OUT;
    ctrl_n.dp_doSR      = state_n == SR;
    ctrl_n.dp_doMC      = (state_n == PASS) && !beat_nxt[0];
    ctrl_n.rk_next      = ((state_n == LOAD) || (state_n == PASS)) &&
                          (beat_nxt == BEAT_W'(BEATS - 1));
`ifdef DSBOX_ALIGN_EN
    ctrl_n.dp_en        = state_n == ALIGN;
`else
    ctrl_n.dp_en        = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ctrl_q <= '0;
    else
      ctrl_q <= ctrl_n;
  end

  assign busy         = ctrl_q.busy;
  assign done         = ctrl_q.done;
  assign load_phase   = ctrl_q.load_phase;
  assign cipher_valid = ctrl_q.cipher_valid;
  assign dp_en        = ctrl_q.dp_en;
  assign dp_doSR      = ctrl_q.dp_doSR;
  assign dp_doMC      = ctrl_q.dp_doMC;
  assign rk_next      = ctrl_q.rk_next;

endmodule
